// File: rtl/spu_pkg.sv
// Shared SPU definitions: stage-packet geometry, field offsets and register-file state encoding.
// Packets are numbered [0:PKT_W-1] with the unit id at bit 0 and the result data in the low-order bits.
package spu_pkg;

    localparam int UNIT_ID_SIZE   = 3;
    localparam int REG_ADDR_WIDTH = 7;
    localparam int QUADWORD       = 128;
    localparam int PKT_W          = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH + QUADWORD;
    localparam int RF_DEPTH       = 1 << REG_ADDR_WIDTH;

    localparam int WR_EN_BIT = UNIT_ID_SIZE;
    localparam int REG_ADDR  = UNIT_ID_SIZE + 1;
    localparam int RESULT    = REG_ADDR + REG_ADDR_WIDTH;

    // Field order matches packet bit 0 onward, so a [0:PKT_W-1] vector maps directly onto it.
    typedef struct packed {
        logic [UNIT_ID_SIZE-1:0]   unit_id;
        logic                      wr_en;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [QUADWORD-1:0]       data;
    } stage_pkt_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/spu_rf_read_port.sv
// One combinational register-file read port; returns zero while the array is not yet ready.
// With SPU_RF_WRITE_BYPASS_EN, a same-cycle write to the read address is passed through (odd wins).
module spu_rf_read_port
    import spu_pkg::*;
(
    input  logic                      rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [QUADWORD-1:0]       arr [RF_DEPTH],
    input  logic                      even_act,
    input  logic [REG_ADDR_WIDTH-1:0] even_addr,
    input  logic [QUADWORD-1:0]       even_dat,
    input  logic                      odd_act,
    input  logic [REG_ADDR_WIDTH-1:0] odd_addr,
    input  logic [QUADWORD-1:0]       odd_dat,
    output logic [QUADWORD-1:0]       rd_dat
);

`ifdef SPU_RF_WRITE_BYPASS_EN
    always_comb begin
        rd_dat = '0;
        if (rd_en) begin
            rd_dat = arr[rd_addr];
            if (even_act && (even_addr == rd_addr)) rd_dat = even_dat;
            if (odd_act && (odd_addr == rd_addr))   rd_dat = odd_dat;
        end
    end
`else
    // The forwarding network covers the write cycle, so the bypass inputs go unused here.
    logic unused_byp;
    assign unused_byp = ^{even_act, even_addr, even_dat, odd_act, odd_addr, odd_dat};

    always_comb begin
        rd_dat = '0;
        if (rd_en) rd_dat = arr[rd_addr];
    end
`endif

endmodule

// File: rtl/spu_regfile_wb.sv
// 128x128 SPU register file written from the FWE8/FWO8 packets, six combinational reads; zeroes itself
// one entry per cycle after reset (128 cycles). Optional write-through: SPU_RF_WRITE_BYPASS_EN.
module spu_regfile_wb
    import spu_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [0:PKT_W-1]          wb_even_pkt,
    input  logic [0:PKT_W-1]          wb_odd_pkt,
    input  logic [REG_ADDR_WIDTH-1:0] rf_addr_ra_rd_even,
    input  logic [REG_ADDR_WIDTH-1:0] rf_addr_rb_rd_even,
    input  logic [REG_ADDR_WIDTH-1:0] rf_addr_rc_rd_even,
    input  logic [REG_ADDR_WIDTH-1:0] rf_addr_ra_rd_odd,
    input  logic [REG_ADDR_WIDTH-1:0] rf_addr_rb_rd_odd,
    input  logic [REG_ADDR_WIDTH-1:0] rf_addr_rc_rd_odd,
    output logic [QUADWORD-1:0]       ra_rd_even,
    output logic [QUADWORD-1:0]       rb_rd_even,
    output logic [QUADWORD-1:0]       rc_rd_even,
    output logic [QUADWORD-1:0]       ra_rd_odd,
    output logic [QUADWORD-1:0]       rb_rd_odd,
    output logic [QUADWORD-1:0]       rc_rd_odd,
    output logic                      rf_ready,
    output logic                      wr_conflict
);

    stage_pkt_t even_p;
    stage_pkt_t odd_p;
    assign even_p = wb_even_pkt;
    assign odd_p  = wb_odd_pkt;

    // Unit id is only meaningful to the forwarding macro.
    logic unused_uid;
    assign unused_uid = ^{even_p.unit_id, odd_p.unit_id};

    rf_state_t                 state, state_nxt;
    logic [REG_ADDR_WIDTH-1:0] clr_addr, clr_addr_nxt;
    logic                      rf_ready_nxt;
    logic                      wr_conflict_nxt;
    logic                      even_act, odd_act;
    logic [QUADWORD-1:0]       mem [RF_DEPTH];

    assign even_act = (state == READY) && even_p.wr_en;
    assign odd_act  = (state == READY) && odd_p.wr_en;

    always_comb begin
        state_nxt       = state;
        clr_addr_nxt    = clr_addr;
        rf_ready_nxt    = rf_ready;
        wr_conflict_nxt = even_act && odd_act && (even_p.addr == odd_p.addr);
        case (state)
            CLEAR: begin
                clr_addr_nxt = clr_addr + 1'b1;
                if (&clr_addr) begin
                    state_nxt    = READY;
                    rf_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= CLEAR;
            clr_addr    <= '0;
            rf_ready    <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_addr    <= clr_addr_nxt;
            rf_ready    <= rf_ready_nxt;
            wr_conflict <= wr_conflict_nxt;
        end
    end

    // Odd is written last so it wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end else begin
                if (even_act) mem[even_p.addr] <= even_p.data;
                if (odd_act)  mem[odd_p.addr]  <= odd_p.data;
            end
        end
    end

    logic [REG_ADDR_WIDTH-1:0] rd_addr [6];
    logic [QUADWORD-1:0]       rd_dat  [6];

    assign rd_addr[0] = rf_addr_ra_rd_even;
    assign rd_addr[1] = rf_addr_rb_rd_even;
    assign rd_addr[2] = rf_addr_rc_rd_even;
    assign rd_addr[3] = rf_addr_ra_rd_odd;
    assign rd_addr[4] = rf_addr_rb_rd_odd;
    assign rd_addr[5] = rf_addr_rc_rd_odd;

    for (genvar i = 0; i < 6; i++) begin : g_rd
        spu_rf_read_port u_rd (
            .rd_en     (state == READY),
            .rd_addr   (rd_addr[i]),
            .arr       (mem),
            .even_act  (even_act),
            .even_addr (even_p.addr),
            .even_dat  (even_p.data),
            .odd_act   (odd_act),
            .odd_addr  (odd_p.addr),
            .odd_dat   (odd_p.data),
            .rd_dat    (rd_dat[i])
        );
    end

    assign ra_rd_even = rd_dat[0];
    assign rb_rd_even = rd_dat[1];
    assign rc_rd_even = rd_dat[2];
    assign ra_rd_odd  = rd_dat[3];
    assign rb_rd_odd  = rd_dat[4];
    assign rc_rd_odd  = rd_dat[5];

endmodule

// File: tb/tb_spu_regfile_wb.sv
// Scoreboard bench for spu_regfile_wb: reference array updated on each write edge, read expectations
// queued when addresses are driven and popped when the combinational outputs are sampled.
module tb_spu_regfile_wb;

    localparam int PW = 139;

    logic          clk = 1'b0;
    logic          reset;
    logic [0:PW-1] wb_even_pkt, wb_odd_pkt;
    logic [6:0]    rf_addr_ra_rd_even, rf_addr_rb_rd_even, rf_addr_rc_rd_even;
    logic [6:0]    rf_addr_ra_rd_odd, rf_addr_rb_rd_odd, rf_addr_rc_rd_odd;
    logic [127:0]  ra_rd_even, rb_rd_even, rc_rd_even, ra_rd_odd, rb_rd_odd, rc_rd_odd;
    logic          rf_ready, wr_conflict;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [127:0]  ref_mem [128];
    logic [127:0]  exp_q [$];

    always #5 clk = ~clk;

    spu_regfile_wb dut (
        .clk                (clk),
        .reset              (reset),
        .wb_even_pkt        (wb_even_pkt),
        .wb_odd_pkt         (wb_odd_pkt),
        .rf_addr_ra_rd_even (rf_addr_ra_rd_even),
        .rf_addr_rb_rd_even (rf_addr_rb_rd_even),
        .rf_addr_rc_rd_even (rf_addr_rc_rd_even),
        .rf_addr_ra_rd_odd  (rf_addr_ra_rd_odd),
        .rf_addr_rb_rd_odd  (rf_addr_rb_rd_odd),
        .rf_addr_rc_rd_odd  (rf_addr_rc_rd_odd),
        .ra_rd_even         (ra_rd_even),
        .rb_rd_even         (rb_rd_even),
        .rc_rd_even         (rc_rd_even),
        .ra_rd_odd          (ra_rd_odd),
        .rb_rd_odd          (rb_rd_odd),
        .rc_rd_odd          (rc_rd_odd),
        .rf_ready           (rf_ready),
        .wr_conflict        (wr_conflict)
    );

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [0:PW-1] mk_pkt(input logic we, input logic [6:0] a, input logic [127:0] d);
        logic [0:PW-1] p;
        p          = '0;
        p[0:2]     = 3'($urandom);
        p[3]       = we;
        p[4 +: 7]  = a;
        p[11 +: 128] = d;
        return p;
    endfunction

    // Starts and ends just after a rising edge.
    task automatic run_clear(input int ncyc, input logic [6:0] junk);
        wb_even_pkt = mk_pkt(1'b1, junk, {8{16'hC0DE}});
        for (int c = 0; c < ncyc; c++) begin
            rf_addr_ra_rd_even = 7'(c);
            rf_addr_rc_rd_odd  = 7'(127 - c);
            #2;
            check_val("clr_rdy", 128'(rf_ready), 128'd0);
            check_val("clr_ra_even", ra_rd_even, 128'd0);
            check_val("clr_rc_odd", rc_rd_odd, 128'd0);
            check_val("clr_conf", 128'(wr_conflict), 128'd0);
            @(posedge clk); #1;
        end
        wb_even_pkt = '0;
        if (ncyc == 128) begin
            for (int i = 0; i < 128; i++) ref_mem[i] = '0;
            check_val("rdy_rise", 128'(rf_ready), 128'd1);
        end
    endtask

    task automatic wr(input logic we_e, input logic [6:0] a_e, input logic [127:0] d_e,
                      input logic we_o, input logic [6:0] a_o, input logic [127:0] d_o);
        logic [127:0] exp_byp;
        wb_even_pkt = mk_pkt(we_e, a_e, d_e);
        wb_odd_pkt  = mk_pkt(we_o, a_o, d_o);
        exp_byp = ref_mem[rf_addr_ra_rd_odd];
`ifdef SPU_RF_WRITE_BYPASS_EN
        if (we_e && a_e == rf_addr_ra_rd_odd) exp_byp = d_e;
        if (we_o && a_o == rf_addr_ra_rd_odd) exp_byp = d_o;
`endif
        #2;
        check_val("wr_cycle_ra_odd", ra_rd_odd, exp_byp);
        @(posedge clk);
        if (we_e) ref_mem[a_e] = d_e;
        if (we_o) ref_mem[a_o] = d_o;
        #1;
        wb_even_pkt = '0;
        wb_odd_pkt  = '0;
        check_val("wr_conflict", 128'(wr_conflict), 128'(we_e && we_o && (a_e == a_o)));
    endtask

    task automatic idle_chk();
        @(posedge clk); #1;
        check_val("conf_pulse_end", 128'(wr_conflict), 128'd0);
    endtask

    task automatic rd_all(input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                          input logic [6:0] a3, input logic [6:0] a4, input logic [6:0] a5,
                          input string tag);
        rf_addr_ra_rd_even = a0; exp_q.push_back(ref_mem[a0]);
        rf_addr_rb_rd_even = a1; exp_q.push_back(ref_mem[a1]);
        rf_addr_rc_rd_even = a2; exp_q.push_back(ref_mem[a2]);
        rf_addr_ra_rd_odd  = a3; exp_q.push_back(ref_mem[a3]);
        rf_addr_rb_rd_odd  = a4; exp_q.push_back(ref_mem[a4]);
        rf_addr_rc_rd_odd  = a5; exp_q.push_back(ref_mem[a5]);
        #2;
        check_val({tag, "_ra_even"}, ra_rd_even, exp_q.pop_front());
        check_val({tag, "_rb_even"}, rb_rd_even, exp_q.pop_front());
        check_val({tag, "_rc_even"}, rc_rd_even, exp_q.pop_front());
        check_val({tag, "_ra_odd"},  ra_rd_odd,  exp_q.pop_front());
        check_val({tag, "_rb_odd"},  rb_rd_odd,  exp_q.pop_front());
        check_val({tag, "_rc_odd"},  rc_rd_odd,  exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        wb_even_pkt = '0;
        wb_odd_pkt  = '0;
        rf_addr_ra_rd_even = '0; rf_addr_rb_rd_even = '0; rf_addr_rc_rd_even = '0;
        rf_addr_ra_rd_odd  = '0; rf_addr_rb_rd_odd  = '0; rf_addr_rc_rd_odd  = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;

        @(posedge clk); #1;
        check_val("rst_rdy", 128'(rf_ready), 128'd0);
        check_val("rst_conf", 128'(wr_conflict), 128'd0);
        reset = 1'b1;

        // Junk write to r20 held through the whole clear, including its final cycle.
        run_clear(128, 7'd20);

        wr(1'b1, 7'd21, {16{8'h77}}, 1'b0, 7'd0, '0);
        rd_all(7'd21, 7'd20, 7'd21, 7'd20, 7'd21, 7'd20, "first_wr");

        wr(1'b1, 7'd5, {16{8'hA5}}, 1'b0, 7'd0, '0);
        wr(1'b0, 7'd6, {16{8'hFF}}, 1'b0, 7'd6, {16{8'hEE}});
        rd_all(7'd6, 7'd5, 7'd6, 7'd5, 7'd6, 7'd6, "r5_r6");

        wr(1'b1, 7'd10, {16{8'h11}}, 1'b1, 7'd10, {16{8'h22}});
        idle_chk();
        rd_all(7'd10, 7'd10, 7'd10, 7'd10, 7'd10, 7'd10, "r10_conf");

        rf_addr_ra_rd_odd = 7'd127;
        wr(1'b0, 7'd0, '0, 1'b1, 7'd127, {8{16'hBEEF}});
        wr(1'b0, 7'd0, '0, 1'b1, 7'd127, {8{16'hDEAD}});
        rd_all(7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, "r127");

        wr(1'b1, 7'd3, {16{8'h33}}, 1'b1, 7'd4, {16{8'h44}});
        idle_chk();
        rd_all(7'd3, 7'd3, 7'd3, 7'd3, 7'd3, 7'd3, "r3");
        rd_all(7'd4, 7'd4, 7'd4, 7'd4, 7'd4, 7'd4, "r4");

        wr(1'b1, 7'd0, {4{32'h0BADF00D}}, 1'b0, 7'd0, '0);
        rd_all(7'd0, 7'd3, 7'd0, 7'd4, 7'd0, 7'd5, "r0");

        for (int k = 0; k < 16; k++) begin
            rf_addr_ra_rd_odd = 7'($urandom_range(0, 15));
            wr(1'($urandom), 7'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
               1'($urandom), 7'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
            rd_all(7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                   7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), "rand");
        end

        // Reset while READY, then again 60 cycles into the clear.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_clear(60, 7'd9);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("mid_clr_rst_rdy", 128'(rf_ready), 128'd0);
        reset = 1'b1;
        run_clear(128, 7'd9);
        rd_all(7'd9, 7'd5, 7'd10, 7'd127, 7'd3, 7'd4, "after_reclr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spu_regfile_wb.md
Name: spu_regfile_wb

Overview:
- 128-entry x 128-bit SPU register file, written at write-back from the final even and odd forward stages (FWE8/FWO8 packets).
- Supplies the six raw operands (ra/rb/rc, even and odd) that the forwarding macro either overrides or passes through.
- Is the write end of the stage-packet interface that the forwarding macro reads.
- Contains an initialisation sequencer that zeroes the array one entry per cycle after reset.

Parameters:
- UNIT_ID_SIZE, 3, unit-id field width at the head of a stage packet.
- REG_ADDR_WIDTH, 7, register address width (128 registers).
- QUADWORD, 128, register width in bits.
- PKT_W, UNIT_ID_SIZE+1+REG_ADDR_WIDTH+QUADWORD (139), stage packet width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low: sampled low at posedge = reset.
- wb_even_pkt  in  PKT_W  even write-back packet [0:PKT_W-1].
  - Field layout: unit id [0:UNIT_ID_SIZE-1], write enable [UNIT_ID_SIZE], address [UNIT_ID_SIZE+1 +: REG_ADDR_WIDTH], data [UNIT_ID_SIZE+1+REG_ADDR_WIDTH +: QUADWORD].
- wb_odd_pkt  in  PKT_W  odd write-back packet, same layout.
- rf_addr_ra_rd_even, rf_addr_rb_rd_even, rf_addr_rc_rd_even  in  REG_ADDR_WIDTH each  even read addresses.
- rf_addr_ra_rd_odd, rf_addr_rb_rd_odd, rf_addr_rc_rd_odd  in  REG_ADDR_WIDTH each  odd read addresses.
- ra_rd_even, rb_rd_even, rc_rd_even, ra_rd_odd, rb_rd_odd, rc_rd_odd  out  QUADWORD each  read data (combinational).
- rf_ready  out  1  high once initialisation is complete.
- wr_conflict  out  1  registered one-cycle pulse: both packets wrote the same address.

Behaviour:
- Reset (reset==0 at posedge):
  - state<=CLEAR, clr_addr<=0, rf_ready<=0, wr_conflict<=0.
  - Array contents are not directly reset.
  - Reset asserted mid-CLEAR or mid-READY restarts the clear from address 0.
- CLEAR state:
  - Each cycle, reg[clr_addr]<=0 and clr_addr increments.
  - The cycle clr_addr==127 is written: state<=READY, rf_ready<=1 (visible the following cycle).
  - CLEAR lasts exactly 128 cycles after reset deasserts.
  - Packet writes are ignored.
  - All read outputs return 0.
  - wr_conflict stays 0.
- READY state:
  - A packet is active when its write-enable bit is 1.
  - Active packet: reg[addr]<=data at the posedge.
  - Unit id is ignored by this block.
  - Both active, same address: odd data is written, and wr_conflict<=1 for one cycle.
  - Both active, different addresses: both written in the same cycle.
  - Write latency: data is readable from the array the cycle after the write edge.
- Reads:
  - Purely combinational: data = reg[addr], with any bypass override below.
  - All six ports are independent; any port may alias any other.
  - Register 0 is an ordinary register (no hardwired zero).
- Boundaries:
  - Address 127 write/read.
  - Write during the final CLEAR cycle is dropped.
  - First write is accepted in the first cycle rf_ready==1.

Optional Feature:
- Macro: SPU_RF_WRITE_BYPASS_EN.
- Defined: in READY, a read address equal to an active packet's address this cycle returns that packet's data (write-through); odd wins if both match.
- Undefined: reads return the pre-write array value in the write cycle; forwarding covers the gap via its stage-8 compare.

Decomposition:
- Shared package (spu_pkg) holds:
  - UNIT_ID_SIZE, REG_ADDR_WIDTH, QUADWORD, PKT_W.
  - Packet field offsets (WR_EN_BIT, REG_ADDR, RESULT).
  - Typedef stage_pkt_t and the rf_state_t enum {CLEAR, READY}.
- One natural sub-module: spu_rf_read_port.
  - Single combinational read mux with the optional bypass compare.
  - Instantiated six times.

Test Plan:
- Reset low 1 cycle, then high: rf_ready==0 for 128 cycles, 1 from cycle 129; every read address returns 0 throughout.
- After ready: even writes r5=0xA5..A5 (enable=1) -> next cycle, rb_rd_even with addr 5 reads 0xA5..A5; a packet with enable=0 to r6 leaves r6==0.
- Both packets write r10 (even 0x1111.., odd 0x2222..) -> r10==0x2222.. next cycle; wr_conflict high exactly one cycle.
- With SPU_RF_WRITE_BYPASS_EN: odd writes r127=0xDEAD.. and ra_rd_odd reads addr 127 in the same cycle -> 0xDEAD..; without the macro -> the previous value.
- Reset asserted at clear cycle 60 -> clear restarts; rf_ready rises 128 cycles after release; a write attempted during CLEAR is absent afterwards.
- Even writes r3 and odd writes r4 in the same cycle -> both readable next cycle on all six ports; wr_conflict stays 0.
